// File: rtl/ipf_pkg.sv
// Shared states, LCU size codes and frame geometry for the IPF frame scheduler.
package ipf_pkg;
    localparam int FRAME_W = 128;
    localparam int ADDR_W  = 14;
    localparam int COORD_W = 7;
    localparam int PIX_W   = 8;

    typedef enum logic [1:0] {IDLE, FETCH, LCU_WAIT, DONE} state_t;

    typedef enum logic [1:0] {
        LCU16   = 2'd0,
        LCU32   = 2'd1,
        LCU64   = 2'd2,
        LCU_BAD = 2'd3
    } lcu_size_t;

    // log2 of the LCU edge length: 16 << size.
    function automatic logic [2:0] size_shift(input logic [1:0] size);
        return 3'd4 + {1'b0, size};
    endfunction
endpackage

// File: rtl/ipf_skid_reg.sv
// One-entry holding register for a memory return that the core cannot take yet.
module ipf_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);
    // NOTE: the data word is reset along with the valid bit; it is a single register, so this costs nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/ipf_lcu_scheduler.sv
// Walks a 128x128 frame LCU by LCU, streams each LCU's pixels into the IPF core
// under busy backpressure, and waits for the core to finish filtering before moving on.
module ipf_lcu_scheduler
    import ipf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic              active,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              ipf_in_en,
    output logic [PIX_W-1:0]  ipf_din,
    output logic [2:0]        ipf_lcu_x,
    output logic [2:0]        ipf_lcu_y,
    output logic [1:0]        ipf_lcu_size,
    input  logic              ipf_busy
);
    state_t     state_q, state_d;
    lcu_size_t  size_q, size_d;
    logic [2:0] lx_q, lx_d, ly_q, ly_d;
    logic [5:0] row_q, row_d, col_q, col_d;
    logic       busy_seen_q, busy_seen_d;
    logic       rd_pending_q;
    logic       cfg_err_d;

    logic             skid_full, skid_push, skid_pop;
    logic [PIX_W-1:0] skid_data;

    logic [2:0]         shift;
    logic [COORD_W-1:0] lcu_s;
    logic [5:0]         pix_max;
    logic [2:0]         lcu_max;
    logic               drained;
    logic [COORD_W-1:0] addr_row, addr_col;

    assign shift   = size_shift(size_q);
    assign lcu_s   = 7'd1 << shift;
    assign pix_max = 6'(lcu_s - 7'd1);
    assign lcu_max = 3'((8'd128 >> shift) - 8'd1);
    assign drained = !rd_pending_q && !skid_full;

    // LCU origin is aligned to S, so OR-ing in the pixel offset equals adding it.
    assign addr_row    = ({4'd0, ly_q} << shift) | 7'(row_q);
    assign addr_col    = ({4'd0, lx_q} << shift) | 7'(col_q);
    assign mem_rd_addr = {addr_row, addr_col};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d     = state_q;
        size_d      = size_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        row_d       = row_q;
        col_d       = col_q;
        busy_seen_d = busy_seen_q;
        cfg_err_d   = 1'b0;
        mem_rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_lcu_size == LCU_BAD) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        size_d      = lcu_size_t'(cfg_lcu_size);
                        lx_d        = '0;
                        ly_d        = '0;
                        row_d       = '0;
                        col_d       = '0;
                        busy_seen_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_rd_en = !ipf_busy && !skid_full;
                if (mem_rd_en) begin
                    if (col_q == pix_max) begin
                        col_d = '0;
                        if (row_q == pix_max) begin
                            row_d   = '0;
                            state_d = LCU_WAIT;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            LCU_WAIT: begin
                // Only a busy pulse seen after the last pixel reached the core marks the end of filtering.
                if (busy_seen_q) begin
                    if (!ipf_busy) begin
                        busy_seen_d = 1'b0;
                        state_d     = FETCH;
                        if (lx_q == lcu_max) begin
                            lx_d = '0;
                            if (ly_q == lcu_max) begin
                                ly_d    = '0;
                                state_d = DONE;
                            end else begin
                                ly_d = ly_q + 3'd1;
                            end
                        end else begin
                            lx_d = lx_q + 3'd1;
                        end
                    end
                end else if (drained && ipf_busy) begin
                    busy_seen_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= LCU16;
            lx_q         <= '0;
            ly_q         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            busy_seen_q  <= 1'b0;
            rd_pending_q <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            lx_q         <= lx_d;
            ly_q         <= ly_d;
            row_q        <= row_d;
            col_q        <= col_d;
            busy_seen_q  <= busy_seen_d;
            rd_pending_q <= mem_rd_en;
            cfg_err      <= cfg_err_d;
        end
    end

    // A return meeting busy is parked; it can never coincide with a full skid since reads stop while it is full.
    assign skid_push = rd_pending_q && ipf_busy;
    assign skid_pop  = skid_full && !ipf_busy;

    ipf_skid_reg #(.W(PIX_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (skid_push),
        .pop  (skid_pop),
        .din  (mem_rd_data),
        .dout (skid_data),
        .full (skid_full)
    );

    assign ipf_in_en    = (rd_pending_q || skid_full) && !ipf_busy;
    assign ipf_din      = ipf_in_en ? (skid_full ? skid_data : mem_rd_data) : '0;
    assign active       = (state_q == FETCH) || (state_q == LCU_WAIT);
    assign frame_done   = (state_q == DONE);
    assign ipf_lcu_x    = lx_q;
    assign ipf_lcu_y    = ly_q;
    assign ipf_lcu_size = size_q;
endmodule

// File: tb/tb_ipf_lcu_scheduler.sv
// Self-checking bench: frame memory + IPF core model, scheduler-order reference and per-cycle compare.
module tb_ipf_lcu_scheduler;
    localparam int FRAME_PIX = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cfg_lcu_size;
    logic        active, frame_done, cfg_err;
    logic        mem_rd_en;
    logic [13:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;
    logic        ipf_in_en;
    logic [7:0]  ipf_din;
    logic [2:0]  ipf_lcu_x, ipf_lcu_y;
    logic [1:0]  ipf_lcu_size;
    logic        ipf_busy;

    ipf_lcu_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .active       (active),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .ipf_in_en    (ipf_in_en),
        .ipf_din      (ipf_din),
        .ipf_lcu_x    (ipf_lcu_x),
        .ipf_lcu_y    (ipf_lcu_y),
        .ipf_lcu_size (ipf_lcu_size),
        .ipf_busy     (ipf_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame memory and reference scheduler order
    logic [7:0] frame_mem [FRAME_PIX];
    int exp_addr [FRAME_PIX];
    int exp_lx   [FRAME_PIX];
    int exp_ly   [FRAME_PIX];
    int dut_addr_log [FRAME_PIX];
    int dut_lx_log   [FRAME_PIX];
    int dut_ly_log   [FRAME_PIX];
    int s2, n_lcu;

    task automatic build_model(input int size);
        int s, n, k;
        s = 16 << size;
        n = 128 / s;
        k = 0;
        for (int ly = 0; ly < n; ly++)
            for (int lx = 0; lx < n; lx++)
                for (int r = 0; r < s; r++)
                    for (int c = 0; c < s; c++) begin
                        exp_addr[k] = (ly * s + r) * 128 + lx * s + c;
                        exp_lx[k]   = lx;
                        exp_ly[k]   = ly;
                        k++;
                    end
        s2    = s * s;
        n_lcu = n * n;
    endtask

    // Memory and core-model drive state
    logic        pend_en = 1'b0;
    logic [13:0] pend_addr = '0;
    int busy_pct = 0;
    int force_low = 0;
    int filt_left = 0;
    int filt_min = 1;
    int filt_span = 0;
    bit ovr_hi = 1'b0;

    always @(negedge clk) begin
        pend_en   = mem_rd_en;
        pend_addr = mem_rd_addr;
    end

    always @(posedge clk) begin
        #1;
        mem_rd_data = pend_en ? frame_mem[pend_addr] : 8'($urandom);
        if (ovr_hi) begin
            ipf_busy = 1'b1;
        end else if (force_low > 0) begin
            ipf_busy = 1'b0;
            force_low--;
        end else if (filt_left > 0) begin
            ipf_busy = 1'b1;
            filt_left--;
            if (filt_left == 0) force_low = 2;
        end else begin
            ipf_busy = (int'($urandom_range(99)) < busy_pct);
        end
    end

    // Compare process
    bit mon_en = 1'b0;
    int rd_idx, beat_idx, lcu_beats, lcus_done, done_cnt;
    int fall_cyc = -10;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd_en) begin
                if (rd_idx < FRAME_PIX) begin
                    dut_addr_log[rd_idx] = int'(mem_rd_addr);
                    dut_lx_log[rd_idx]   = int'(ipf_lcu_x);
                    dut_ly_log[rd_idx]   = int'(ipf_lcu_y);
                    check("rd_addr", int'(mem_rd_addr), exp_addr[rd_idx]);
                    check("rd_lcu_x", int'(ipf_lcu_x), exp_lx[rd_idx]);
                    check("rd_lcu_y", int'(ipf_lcu_y), exp_ly[rd_idx]);
                end else begin
                    check("read_count", rd_idx + 1, FRAME_PIX);
                end
                check("active_on_read", int'(active), 1);
                rd_idx++;
            end
            if (ipf_in_en) begin
                check("beat_while_busy", int'(ipf_busy), 0);
                if (beat_idx < FRAME_PIX) begin
                    check("din", int'(ipf_din), int'(frame_mem[exp_addr[beat_idx]]));
                    check("beat_lcu_x", int'(ipf_lcu_x), exp_lx[beat_idx]);
                    check("beat_lcu_y", int'(ipf_lcu_y), exp_ly[beat_idx]);
                end else begin
                    check("beat_count", beat_idx + 1, FRAME_PIX);
                end
                beat_idx++;
                lcu_beats++;
                if (lcu_beats == s2) begin
                    int fl;
                    fl = filt_min + int'($urandom_range(filt_span));
                    lcu_beats = 0;
                    lcus_done++;
                    filt_left = fl;
                    fall_cyc  = cyc + fl + 1;
                end
            end
            if (cyc == fall_cyc) begin
                check("wait_no_read", int'(mem_rd_en), 0);
                check("wait_active", int'(active), 1);
            end
            if (cyc == fall_cyc + 1) begin
                if (lcus_done == n_lcu) begin
                    check("frame_done_timing", int'(frame_done), 1);
                    check("active_drop", int'(active), 0);
                end else begin
                    check("next_lcu_read", int'(mem_rd_en), 1);
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, int'(active), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_cfg_err"}, int'(cfg_err), 0);
        check({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
        check({tag, "_mem_rd_addr"}, int'(mem_rd_addr), 0);
        check({tag, "_ipf_in_en"}, int'(ipf_in_en), 0);
        check({tag, "_ipf_din"}, int'(ipf_din), 0);
        check({tag, "_lcu_x"}, int'(ipf_lcu_x), 0);
        check({tag, "_lcu_y"}, int'(ipf_lcu_y), 0);
        check({tag, "_lcu_size"}, int'(ipf_lcu_size), 0);
    endtask

    task automatic start_frame(input int size, input int pct, input int fmin, input int fspan);
        build_model(size);
        @(negedge clk);
        rd_idx = 0; beat_idx = 0; lcu_beats = 0; lcus_done = 0; done_cnt = 0;
        fall_cyc = -10; busy_pct = pct; filt_min = fmin; filt_span = fspan;
        force_low = 3; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_lcu_size = 2'(size);
        @(negedge clk);
        check("idle_before_accept", int'(active), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("first_read_latency", int'(mem_rd_en), 1);
        check("active_after_start", int'(active), 1);
        check("lcu_size_latched", int'(ipf_lcu_size), size);
        @(negedge clk);
        check("first_beat_latency", int'(ipf_in_en), 1);
    endtask

    task automatic run_frame(input int size, input int pct, input int fmin, input int fspan, input bit mid_start);
        start_frame(size, pct, fmin, fspan);
        if (mid_start) begin
            for (int i = 0; i < 20000 && rd_idx < 5000; i++) @(negedge clk);
            @(posedge clk); #1;
            start = 1'b1;
            cfg_lcu_size = 2'd0;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("mid_start_size_kept", int'(ipf_lcu_size), size);
            check("mid_start_active", int'(active), 1);
        end
        for (int i = 0; i < 40000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        busy_pct = 0;
        check("frame_done_count", done_cnt, 1);
        check("total_reads", rd_idx, FRAME_PIX);
        check("total_beats", beat_idx, FRAME_PIX);
        check("lcu_count", lcus_done, n_lcu);
        check("active_after_done", int'(active), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int err_cnt, act_seen, rd_seen;
        rst = 1'b1; start = 1'b0; cfg_lcu_size = 2'd0; ipf_busy = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < FRAME_PIX; i++) frame_mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Illegal size: one cfg_err pulse, nothing else moves
        err_cnt = 0; act_seen = 0; rd_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_lcu_size = 2'd3;
        @(negedge clk);
        err_cnt += int'(cfg_err); act_seen += int'(active); rd_seen += int'(mem_rd_en);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            err_cnt += int'(cfg_err); act_seen += int'(active); rd_seen += int'(mem_rd_en);
        end
        check("cfg_err_pulses", err_cnt, 1);
        check("cfg_err_active", act_seen, 0);
        check("cfg_err_reads", rd_seen, 0);
        check("cfg_err_size", int'(ipf_lcu_size), 0);

        // 64x64 LCUs, no backpressure, restart attempt mid-frame
        run_frame(2, 0, 10, 0, 1'b1);
        check("model_first_addr", exp_addr[0], 0);
        check("model_lcu10_addr", exp_addr[4096], 64);
        check("s64_first_addr", dut_addr_log[0], 0);
        check("s64_lcu10_addr", dut_addr_log[4096], 64);
        check("s64_last_addr", dut_addr_log[16383], 16383);
        check("s64_lcu1_x", dut_lx_log[4096], 1);
        check("s64_lcu1_y", dut_ly_log[4096], 0);
        check("s64_lcu2_x", dut_lx_log[8192], 0);
        check("s64_lcu2_y", dut_ly_log[8192], 1);
        check("s64_lcu3_x", dut_lx_log[12288], 1);
        check("s64_lcu3_y", dut_ly_log[12288], 1);

        // 16x16 LCUs, no backpressure
        run_frame(0, 0, 3, 0, 1'b0);
        check("model_s16_r1c0", exp_addr[272], 144);
        check("s16_r1c0_addr", dut_addr_log[272], 144);
        check("s16_lcu7_x", dut_lx_log[7 * 256], 7);
        check("s16_lcu7_y", dut_ly_log[7 * 256], 0);
        check("s16_lcu8_x", dut_lx_log[8 * 256], 0);
        check("s16_lcu8_y", dut_ly_log[8 * 256], 1);

        // 32x32 LCUs, random busy including return cycles, random filter lengths
        run_frame(1, 15, 1, 7, 1'b0);

        // Reset mid-LCU while a return is parked in the skid
        start_frame(1, 0, 2, 0);
        for (int i = 0; i < 2000 && rd_idx < 300; i++) @(negedge clk);
        for (int i = 0; i < 100 && !mem_rd_en; i++) @(negedge clk);
        ovr_hi = 1'b1;
        @(negedge clk);
        check("held_no_beat", int'(ipf_in_en), 0);
        check("held_busy", int'(ipf_busy), 1);
        mon_en = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        ovr_hi = 1'b0; filt_left = 0; force_low = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(2, 8, 1, 5, 1'b0);
        check("after_reset_first_addr", dut_addr_log[0], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
